// File: rtl/bsg_manycore_host_link_bridge_if.sv
// Host- and link-facing bundle of the manycore host link bridge.
// Widths are derived from the same base parameters as the bridge itself.
// slave = bridge side, master = host/manycore side.
interface bsg_manycore_host_link_bridge_if #(
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 32,
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int load_id_width_p   = 5,
  parameter int max_out_credits_p = 16
) ();

  localparam int pkt_w_lp  = addr_width_p + data_width_p
                           + 2*(x_cord_width_p + y_cord_width_p) + 6;
  localparam int ret_w_lp  = 2 + data_width_p + load_id_width_p
                           + x_cord_width_p + y_cord_width_p;
  localparam int link_w_lp = pkt_w_lp + ret_w_lp + 4;
  localparam int cred_w_lp = $clog2(max_out_credits_p + 1);

  logic                 host_req_v_i;
  logic [pkt_w_lp-1:0]  host_req_i;
  logic                 host_req_ready_o;
  logic                 host_rsp_v_o;
  logic [ret_w_lp-1:0]  host_rsp_o;
  logic                 host_rsp_yumi_i;
  logic                 host_in_v_o;
  logic [pkt_w_lp-1:0]  host_in_o;
  logic                 host_in_yumi_i;
  logic                 host_in_rsp_v_i;
  logic [ret_w_lp-1:0]  host_in_rsp_i;
  logic                 host_in_rsp_ready_o;
  logic [link_w_lp-1:0] link_sif_i;
  logic [link_w_lp-1:0] link_sif_o;
  logic [cred_w_lp-1:0] credits_o;
  logic                 idle_o;
  logic                 credit_err_o;

  modport slave (
    input  host_req_v_i, host_req_i, host_rsp_yumi_i, host_in_yumi_i,
           host_in_rsp_v_i, host_in_rsp_i, link_sif_i,
    output host_req_ready_o, host_rsp_v_o, host_rsp_o, host_in_v_o, host_in_o,
           host_in_rsp_ready_o, link_sif_o, credits_o, idle_o, credit_err_o
  );

  modport master (
    output host_req_v_i, host_req_i, host_rsp_yumi_i, host_in_yumi_i,
           host_in_rsp_v_i, host_in_rsp_i, link_sif_i,
    input  host_req_ready_o, host_rsp_v_o, host_rsp_o, host_in_v_o, host_in_o,
           host_in_rsp_ready_o, link_sif_o, credits_o, idle_o, credit_err_o
  );

endinterface

// File: rtl/bsg_manycore_host_link_bridge.sv
// Small registered FIFO: storage array with read/write pointers and an occupancy count.
// Latency: 1 cycle from push to v_o.
// Backpressure: ready_o = not full; pop only when yumi_i and v_o.
module bsg_manycore_host_link_bridge_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                push, pop;

  assign ready_o = (cnt_q != cnt_w_lp'(els_p));
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  // Pointer and occupancy next-state; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == last_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == last_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO and drops whatever it held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; validity comes from the count.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// Host endpoint of the manycore IO link: credited host requests out, returns in, and manycore requests/host replies.
// Latency: 1 cycle through each FIFO (host accept -> fwd.v, rev accept -> host_rsp_v_o).
// Backpressure: each path stalls independently on its own FIFO; outgoing requests also stall at zero credits.
module bsg_manycore_host_link_bridge #(
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 32,
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int load_id_width_p   = 5,
  parameter int max_out_credits_p = 16,
  parameter int req_fifo_els_p    = 2,
  parameter int rsp_fifo_els_p    = 4,
  parameter int in_fifo_els_p     = 4
) (
  input logic clk_i,
  input logic reset_ni,
  bsg_manycore_host_link_bridge_if.slave io
);

  localparam int pkt_w_lp  = addr_width_p + data_width_p
                           + 2*(x_cord_width_p + y_cord_width_p) + 6;
  localparam int ret_w_lp  = 2 + data_width_p + load_id_width_p
                           + x_cord_width_p + y_cord_width_p;
  localparam int cred_w_lp = $clog2(max_out_credits_p + 1);
  localparam logic [cred_w_lp-1:0] cred_max_lp = cred_w_lp'(max_out_credits_p);

  // ready_and_rev in each channel acknowledges the opposite-direction channel of the same name.
  typedef struct packed {
    logic                v;
    logic [pkt_w_lp-1:0] data;
    logic                ready_and_rev;
  } fwd_s;

  typedef struct packed {
    logic                v;
    logic [ret_w_lp-1:0] data;
    logic                ready_and_rev;
  } rev_s;

  typedef struct packed {
    fwd_s fwd;
    rev_s rev;
  } link_s;

  link_s link_in, link_out;
  assign link_in       = io.link_sif_i;
  assign io.link_sif_o = link_out;

  // Reset: assert immediately, release two clocks after reset_ni rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset synchronizer chain.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Request path: host -> req FIFO -> link fwd out, metered by credits.
  logic                req_rdy, req_v, fwd_hs;
  logic [pkt_w_lp-1:0] req_dat;
  logic [cred_w_lp-1:0] credits_q, credits_d;
  logic                 credit_err_q, credit_err_d;

  bsg_manycore_host_link_bridge_fifo #(.width_p(pkt_w_lp), .els_p(req_fifo_els_p)) req_fifo (
    .clk_i(clk_i), .rst_ni(rst_n),
    .v_i(io.host_req_v_i), .data_i(io.host_req_i), .ready_o(req_rdy),
    .v_o(req_v), .data_o(req_dat), .yumi_i(fwd_hs)
  );

  assign io.host_req_ready_o = req_rdy & rst_n;
  assign link_out.fwd.v      = req_v & (credits_q != '0);
  assign link_out.fwd.data   = req_dat;
  assign fwd_hs              = link_out.fwd.v & link_in.fwd.ready_and_rev;

  // Return path: link rev in -> rsp FIFO -> host.
  logic rsp_rdy, ret_hs;

  bsg_manycore_host_link_bridge_fifo #(.width_p(ret_w_lp), .els_p(rsp_fifo_els_p)) rsp_fifo (
    .clk_i(clk_i), .rst_ni(rst_n),
    .v_i(link_in.rev.v), .data_i(link_in.rev.data), .ready_o(rsp_rdy),
    .v_o(io.host_rsp_v_o), .data_o(io.host_rsp_o), .yumi_i(io.host_rsp_yumi_i)
  );

  assign link_out.rev.ready_and_rev = rsp_rdy & rst_n;
  assign ret_hs                     = link_in.rev.v & link_out.rev.ready_and_rev;

  // Incoming path: link fwd in -> in FIFO -> host.
  logic in_rdy;

  bsg_manycore_host_link_bridge_fifo #(.width_p(pkt_w_lp), .els_p(in_fifo_els_p)) in_fifo (
    .clk_i(clk_i), .rst_ni(rst_n),
    .v_i(link_in.fwd.v), .data_i(link_in.fwd.data), .ready_o(in_rdy),
    .v_o(io.host_in_v_o), .data_o(io.host_in_o), .yumi_i(io.host_in_yumi_i)
  );

  assign link_out.fwd.ready_and_rev = in_rdy & rst_n;

  // Reply path: host replies -> 2-entry FIFO -> link rev out, uncredited.
  logic rep_rdy, rep_v;

  bsg_manycore_host_link_bridge_fifo #(.width_p(ret_w_lp), .els_p(2)) rep_fifo (
    .clk_i(clk_i), .rst_ni(rst_n),
    .v_i(io.host_in_rsp_v_i), .data_i(io.host_in_rsp_i), .ready_o(rep_rdy),
    .v_o(rep_v), .data_o(link_out.rev.data),
    .yumi_i(rep_v & link_in.rev.ready_and_rev)
  );

  assign io.host_in_rsp_ready_o = rep_rdy & rst_n;
  assign link_out.rev.v         = rep_v;

  // Credit next-state: issue spends, return refunds; a refund at max is an error and saturates.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (fwd_hs && !ret_hs) begin
      credits_d = credits_q - cred_w_lp'(1);
    end else if (ret_hs && !fwd_hs) begin
      if (credits_q == cred_max_lp) credit_err_d = 1'b1;
      else                          credits_d    = credits_q + cred_w_lp'(1);
    end
  end

  // Credit counter and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      credits_q    <= cred_max_lp;
      credit_err_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign io.credits_o    = credits_q;
  assign io.credit_err_o = credit_err_q;
  assign io.idle_o       = (credits_q == cred_max_lp) & ~req_v & ~io.host_rsp_v_o
                         & ~io.host_in_v_o & ~rep_v;

endmodule

// File: tb/tb_bsg_manycore_host_link_bridge.sv
// Directed bench for the manycore host link bridge.
// Drives inputs on the falling edge, samples 1 ns later, records handshakes per cycle.
// Expected values are hand-derived constants and a simple in-order model.
module tb_bsg_manycore_host_link_bridge;

  localparam int AW = 28, DW = 32, XW = 4, YW = 4, LW = 5, MAXC = 16;
  localparam int PKT_W = AW + DW + 2*(XW + YW) + 6;
  localparam int RET_W = 2 + DW + LW + XW + YW;

  typedef struct packed {
    logic             v;
    logic [PKT_W-1:0] data;
    logic             ready_and_rev;
  } fwd_s;
  typedef struct packed {
    logic             v;
    logic [RET_W-1:0] data;
    logic             ready_and_rev;
  } rev_s;
  typedef struct packed {
    fwd_s fwd;
    rev_s rev;
  } link_s;

  logic clk = 1'b0;
  logic reset_ni;
  link_s li, lo;

  always #5 clk = ~clk;

  bsg_manycore_host_link_bridge_if #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW),
    .y_cord_width_p(YW), .load_id_width_p(LW), .max_out_credits_p(MAXC)
  ) io ();

  assign io.link_sif_i = li;
  assign lo            = io.link_sif_o;

  bsg_manycore_host_link_bridge #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW),
    .y_cord_width_p(YW), .load_id_width_p(LW), .max_out_credits_p(MAXC),
    .req_fifo_els_p(2), .rsp_fifo_els_p(4), .in_fifo_els_p(4)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_ni),
    .io(io.slave)
  );

  int checks = 0;
  int failures = 0;
  int req_acc = 0;
  int ret_acc = 0;
  int cred_peak;
  logic [PKT_W-1:0] fwd_q[$];
  logic [RET_W-1:0] rsp_q[$];
  logic [PKT_W-1:0] fin_pkt;
  logic [RET_W-1:0] rep_pkt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk_req(input int i);
    logic [95:0] t;
    t = {32'hA11C_0000 + 32'(i), 32'h5EED_0000 ^ 32'(i), 32'h0000_0100 + 32'(i)};
    return t[PKT_W-1:0];
  endfunction

  function automatic logic [RET_W-1:0] mk_ret(input int i);
    logic [63:0] t;
    t = {32'hBEEF_0000 + 32'(i), 32'hCAFE_0000 + 32'(i)};
    return t[RET_W-1:0];
  endfunction

  // Called just after a falling edge with inputs set: records the handshakes of the coming rising edge.
  task automatic tick();
    #1;
    if (lo.fwd.v && li.fwd.ready_and_rev)       fwd_q.push_back(lo.fwd.data);
    if (io.host_rsp_v_o && io.host_rsp_yumi_i)  rsp_q.push_back(io.host_rsp_o);
    if (io.host_req_v_i && io.host_req_ready_o) req_acc++;
    if (li.rev.v && lo.rev.ready_and_rev)       ret_acc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    fin_pkt = 82'h3_C0FF_EE00_0000_FEED_F100;
    rep_pkt = 47'h7ABC_1234_5678;
    reset_ni = 1'b0;
    li = '0;
    io.host_req_v_i = 1'b0;    io.host_req_i = '0;
    io.host_rsp_yumi_i = 1'b0; io.host_in_yumi_i = 1'b0;
    io.host_in_rsp_v_i = 1'b0; io.host_in_rsp_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_credits", io.credits_o, MAXC);
    check("rst_idle", io.idle_o, 1);
    check("rst_err", io.credit_err_o, 0);
    check("rst_fwd_v", lo.fwd.v, 0);
    check("rst_rev_v", lo.rev.v, 0);
    check("rst_rsp_v", io.host_rsp_v_o, 0);
    check("rst_in_v", io.host_in_v_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    repeat (3) tick();

    // 20 back-to-back requests, manycore accepts but never returns
    li.fwd.ready_and_rev = 1'b1;
    io.host_req_v_i = 1'b1;
    io.host_req_i = mk_req(0);
    #1;
    check("lat_empty_fwd_v", lo.fwd.v, 0);
    tick();
    check("lat_1cyc_fwd_v", lo.fwd.v, 1);
    for (int c = 0; c < 40; c++) begin
      io.host_req_v_i = (req_acc < 20);
      io.host_req_i = mk_req(req_acc);
      tick();
    end
    #1;
    check("burst_fwd_count", fwd_q.size(), 16);
    check("burst_fwd_v", lo.fwd.v, 0);
    check("burst_credits", io.credits_o, 0);
    check("burst_req_ready", io.host_req_ready_o, 0);
    check("burst_req_acc", req_acc, 18);

    // One return per cycle: remaining 4 issue while credits sit at 1
    cred_peak = 0;
    for (int c = 0; c < 100; c++) begin
      if (fwd_q.size() == 20 && rsp_q.size() == 20) break;
      io.host_req_v_i = (req_acc < 20);
      io.host_req_i = mk_req(req_acc);
      li.rev.v = (ret_acc < 20);
      li.rev.data = mk_ret(ret_acc);
      io.host_rsp_yumi_i = io.host_rsp_v_o;
      #1;
      if (fwd_q.size() < 20 && int'(io.credits_o) > cred_peak) cred_peak = int'(io.credits_o);
      tick();
    end
    li.rev.v = 1'b0;
    io.host_req_v_i = 1'b0;
    io.host_rsp_yumi_i = 1'b0;
    tick();
    check("ret_cred_peak", cred_peak, 1);
    check("ret_fwd_count", fwd_q.size(), 20);
    check("ret_rsp_count", rsp_q.size(), 20);
    check("ret_credits", io.credits_o, MAXC);
    check("ret_idle", io.idle_o, 1);
    check("ret_err", io.credit_err_o, 0);

    // Return FIFO full: 5 returns with host not consuming
    for (int c = 0; c < 30 && fwd_q.size() < 25; c++) begin
      io.host_req_v_i = (req_acc < 25);
      io.host_req_i = mk_req(req_acc);
      tick();
    end
    io.host_req_v_i = 1'b0;
    #1;
    check("full_pre_credits", io.credits_o, 11);
    li.rev.v = 1'b1;
    for (int c = 0; c < 5; c++) begin
      li.rev.data = mk_ret(ret_acc);
      tick();
    end
    check("full_accepted", ret_acc, 24);
    check("full_rev_ready", lo.rev.ready_and_rev, 0);
    check("full_rsp_v", io.host_rsp_v_o, 1);
    io.host_rsp_yumi_i = 1'b1;
    tick();
    check("full_pop_cycle", ret_acc, 24);
    io.host_rsp_yumi_i = 1'b0;
    tick();
    check("full_fifth_accept", ret_acc, 25);
    li.rev.v = 1'b0;
    for (int c = 0; c < 20 && rsp_q.size() < 25; c++) begin
      io.host_rsp_yumi_i = io.host_rsp_v_o;
      tick();
    end
    io.host_rsp_yumi_i = 1'b0;
    #1;
    check("full_drained", rsp_q.size(), 25);
    check("full_credits", io.credits_o, MAXC);
    check("full_err", io.credit_err_o, 0);
    for (int i = 0; i < 25; i++) begin
      if (i < fwd_q.size()) check($sformatf("fwd_order_%0d", i), fwd_q[i], mk_req(i));
      if (i < rsp_q.size()) check($sformatf("rsp_order_%0d", i), rsp_q[i], mk_ret(i));
    end

    // Return with credits already full
    li.rev.v = 1'b1;
    li.rev.data = mk_ret(99);
    tick();
    li.rev.v = 1'b0;
    #1;
    check("err_set", io.credit_err_o, 1);
    check("err_credits_hold", io.credits_o, MAXC);
    io.host_rsp_yumi_i = 1'b1;
    tick();
    io.host_rsp_yumi_i = 1'b0;
    check("err_sticky", io.credit_err_o, 1);

    // Manycore-originated finish packet and host reply
    li.fwd.v = 1'b1;
    li.fwd.data = fin_pkt;
    #1;
    check("in_fwd_ready", lo.fwd.ready_and_rev, 1);
    tick();
    li.fwd.v = 1'b0;
    check("in_v", io.host_in_v_o, 1);
    check("in_data", io.host_in_o, fin_pkt);
    io.host_in_yumi_i = 1'b1;
    tick();
    io.host_in_yumi_i = 1'b0;
    check("in_v_after_pop", io.host_in_v_o, 0);
    li.rev.ready_and_rev = 1'b0;
    io.host_in_rsp_v_i = 1'b1;
    io.host_in_rsp_i = rep_pkt;
    #1;
    check("rep_ready", io.host_in_rsp_ready_o, 1);
    tick();
    io.host_in_rsp_v_i = 1'b0;
    check("rep_rev_v", lo.rev.v, 1);
    check("rep_rev_data", lo.rev.data, rep_pkt);
    check("rep_not_idle", io.idle_o, 0);
    li.rev.ready_and_rev = 1'b1;
    tick();
    check("rep_rev_v_done", lo.rev.v, 0);
    check("rep_idle", io.idle_o, 1);

    // Reset asserted mid-operation drops held packets
    li.fwd.ready_and_rev = 1'b0;
    li.fwd.v = 1'b1;
    li.fwd.data = fin_pkt;
    io.host_req_v_i = 1'b1;
    io.host_req_i = mk_req(50);
    tick();
    tick();
    check("mid_busy", io.idle_o, 0);
    reset_ni = 1'b0;
    #2;
    check("mid_rst_credits", io.credits_o, MAXC);
    check("mid_rst_idle", io.idle_o, 1);
    check("mid_rst_fwd_v", lo.fwd.v, 0);
    check("mid_rst_in_v", io.host_in_v_o, 0);
    check("mid_rst_err", io.credit_err_o, 0);
    li = '0;
    io.host_req_v_i = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", io.idle_o, 1);
    check("post_rst_fwd_v", lo.fwd.v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
